wb_result_fifo: RTL and testbench
=================================

Name: wb_result_fifo

Overview:
- Sits directly downstream of the CPU top level. Consumes the 16-bit write-back result (DataOut / ResultW) together with its destination register address and a write-back valid strobe.
- Buffers each result in a small first-word-fall-through FIFO and hands entries to a host or debug port over a valid/ready handshake.
- Flags any result lost to overflow and counts lost results. The CPU pipeline is never stalled by this block.

Parameters:
- DATA_W, 16, width of one write-back result
- DEST_W, 4, width of the destination register address
- DEPTH, 8, number of FIFO entries; must be a power of two
- ADDR_W, 3, log2(DEPTH)
- DROP_W, 8, width of the saturating dropped-result counter

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  write-back strobe (RegWrite in W stage); in_data/in_dest are sampled when high
- in_data  input  DATA_W  write-back result from the CPU
- in_dest  input  DEST_W  destination register address of the result
- out_valid  output  1  head entry available
- out_data  output  DATA_W  head entry data
- out_dest  output  DEST_W  head entry destination address
- out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both high
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- ovf_clr  input  1  clears the overflow flag and drop_cnt
- overflow  output  1  sticky; set when a result was dropped
- drop_cnt  output  DROP_W  saturating count of dropped results

Behaviour:
- Reset (reset == 0 at a rising edge): wr_ptr, rd_ptr and count go to 0. overflow = 0, drop_cnt = 0. All stored entries are discarded, including on a reset mid-stream. Outputs after reset: out_valid = 0, out_data = 0, out_dest = 0, empty = 1, full = 0.
- Storage: DEPTH entries of {dest, data}. wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
- Push: push = in_valid && (!full || pop).
  - On push, {in_dest, in_data} is written at wr_ptr and wr_ptr increments.
- Pop: pop = out_valid && out_ready. On pop, rd_ptr increments.
- Count: count' = count + push - pop.
- Output timing (first-word-fall-through):
  - out_valid = !empty.
  - out_data/out_dest come combinationally from the entry at rd_ptr when out_valid = 1, else 0.
  - Latency: a push at edge N into an empty FIFO gives out_valid = 1 in the cycle after edge N.
  - There is no same-cycle bypass from input to output.
- Simultaneous push and pop:
  - When full: both are performed; count stays at DEPTH and full stays 1.
  - When empty: pop is impossible (out_valid = 0), so only the push occurs.
- Overflow (in_valid && full && !pop):
  - The result is dropped and the FIFO contents are unchanged.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 2^DROP_W - 1.
- ovf_clr: overflow and drop_cnt go to 0 on the next edge. If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- out_ready while empty has no effect. rd_ptr never passes wr_ptr.
- Handshake stability: once out_valid = 1, the head entry does not change until it is popped or reset is asserted.

Test Plan:
- Reset then push three results (dest 1/0x0011, 2/0x0022, 3/0x0033) with out_ready = 0 -> count = 3, out_valid = 1, head 1/0x0011 visible one cycle after the first push; then hold out_ready = 1 -> pops in order 0x0011, 0x0022, 0x0033, then empty = 1, out_data = 0.
- Fill with 8 pushes (data 0x1000..0x1007), then push 0xBEEF with out_ready = 0 -> full = 1, 0xBEEF dropped, overflow = 1, drop_cnt = 1, head still 0x1000.
- FIFO full, in_valid = 1 (0xAAAA) with out_ready = 1 in the same cycle -> 0x1000 popped, 0xAAAA accepted, count stays 8, overflow unchanged; 0xAAAA emerges 8th after the remaining 7.
- Wrap-around: 20 push/pop pairs interleaved at 1-2 entry occupancy -> data order preserved across pointer wrap, count never exceeds 2.
- Overflow 300 times with FIFO full -> drop_cnt saturates at 255. Then ovf_clr together with one more drop -> overflow = 1, drop_cnt = 1. Then ovf_clr alone -> 0/0.
- Push 5 entries, assert reset for one cycle mid-stream while in_valid = 1 -> count = 0, out_valid = 0, overflow = 0; no entry from before reset ever appears at the output.

Source files
------------

// File: rtl/wb_result_fifo.sv
// Write-back result capture: FWFT FIFO of {dest, data}, head visible the cycle after a push.
// Never stalls the CPU; results arriving while full (and not popping) are dropped and counted.

module wb_sync_fifo #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_vld,
  input  logic [WIDTH-1:0]  wr_dat,
  output logic              wr_acc,
  output logic              rd_vld,
  output logic [WIDTH-1:0]  rd_dat,
  input  logic              rd_rdy,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;

  assign full   = (level == DEPTH_L);
  assign empty  = (level == '0);
  assign rd_vld = !empty;
  assign pop    = rd_vld && rd_rdy;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr_acc = wr_vld && (!full || pop);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem[wr_ptr] <= wr_dat;
  end

endmodule

module wb_result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  input  logic              ovf_clr,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  entry_t wr_entry;
  entry_t rd_entry;
  logic   accepted;
  logic   drop;

  assign wr_entry.dest = in_dest;
  assign wr_entry.data = in_data;

  wb_sync_fifo #(
    .WIDTH  ($bits(entry_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (in_valid),
    .wr_dat (wr_entry),
    .wr_acc (accepted),
    .rd_vld (out_valid),
    .rd_dat (rd_entry),
    .rd_rdy (out_ready),
    .level  (count),
    .full   (full),
    .empty  (empty)
  );

  assign out_data = rd_entry.data;
  assign out_dest = rd_entry.dest;
  assign drop     = in_valid && !accepted;

  // A drop in the same cycle as ovf_clr restarts the count at one rather than clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != DROP_MAX)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_result_fifo.sv
// Directed bench for wb_result_fifo with a queue scoreboard of expected {dest, data} entries.
module tb_wb_result_fifo;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_dest;
  logic        out_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        ovf_clr;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [19:0] q[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_drp = 8'd0;
  bit          track = 1'b0;
  int          maxc  = 0;

  wb_result_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a,
                       input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    in_dest   = a;
    out_ready = r;
    ovf_clr   = c;
  endtask

  // Check the DUT against the scoreboard mid-cycle, then advance the model across one edge.
  task automatic tick();
    logic m_pop, m_push, m_drop;
    @(negedge clk);
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 8));
    if (q.size() != 0) begin
      chk("head_data", 32'(out_data), 32'(q[0][15:0]));
      chk("head_dest", 32'(out_dest), 32'(q[0][19:16]));
    end else begin
      chk("idle_out", 32'({out_dest, out_data}), 32'd0);
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drp));
    if (track && int'(count) > maxc) maxc = int'(count);
    m_pop  = out_ready && (q.size() != 0);
    m_push = in_valid && ((q.size() < 8) || m_pop);
    m_drop = in_valid && !m_push;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_drp = 8'd0;
    end else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back({in_dest, in_data});
      if (m_drop) begin
        m_ovf = 1'b1;
        if (ovf_clr) m_drp = 8'd1;
        else if (m_drp != 8'hFF) m_drp = m_drp + 8'd1;
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
        m_drp = 8'd0;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 16'h0, 4'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    tick();

    // Three pushes held back, then drained in order.
    drive(1, 16'h0011, 4'd1, 0, 0); tick();
    chk("fwft_head", 32'(out_data), 32'h0011);
    drive(1, 16'h0022, 4'd2, 0, 0); tick();
    drive(1, 16'h0033, 4'd3, 0, 0); tick();
    chk("three_count", 32'(count), 32'd3);
    drive(0, 16'h0, 4'h0, 1, 0);
    repeat (4) tick();
    chk("drained_empty", 32'(empty), 32'd1);

    // Fill, then overflow once.
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'h1000 + 16'(i), 4'(i), 0, 0); tick();
    end
    drive(1, 16'hBEEF, 4'hF, 0, 0); tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt1", 32'(drop_cnt), 32'd1);
    chk("ovf_head", 32'(out_data), 32'h1000);

    // Push and pop together while full.
    drive(1, 16'hAAAA, 4'hA, 1, 0); tick();
    chk("full_pp_count", 32'(count), 32'd8);
    chk("full_pp_full", 32'(full), 32'd1);
    chk("full_pp_cnt", 32'(drop_cnt), 32'd1);
    drive(0, 16'h0, 4'h0, 1, 0);
    repeat (9) tick();

    // Pointer wrap at 1-2 entries of occupancy.
    track = 1'b1;
    drive(1, 16'h3000, 4'h0, 0, 0); tick();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 16'h3000 + 16'(i), 4'(i), 0, 0); tick();
      drive(0, 16'h0, 4'h0, 1, 0); tick();
    end
    drive(0, 16'h0, 4'h0, 1, 0); tick(); tick();
    track = 1'b0;
    chk("wrap_max_count", 32'(maxc), 32'd2);

    // Saturating drop counter and clear/drop priority.
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'h2000 + 16'(i), 4'(i), 0, 0); tick();
    end
    for (int i = 0; i < 300; i++) begin
      drive(1, 16'hDEAD, 4'hD, 0, 0); tick();
    end
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    drive(1, 16'hD00D, 4'hD, 0, 1); tick();
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    drive(0, 16'h0, 4'h0, 0, 1); tick();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(drop_cnt), 32'd0);
    drive(0, 16'h0, 4'h0, 1, 0);
    repeat (9) tick();

    // Reset mid-stream with a push pending.
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'h5000 + 16'(i), 4'(i), 0, 0); tick();
    end
    drive(1, 16'h5555, 4'h5, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    drive(1, 16'h7777, 4'h7, 0, 0); tick();
    chk("post_rst_head", 32'(out_data), 32'h7777);
    drive(0, 16'h0, 4'h0, 1, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
